// File: rtl/pattern_stream_gen.sv
// rtl/pattern_stream_gen.sv - AXI4-Stream video test-pattern source with frame/line markers
module pattern_stream_gen #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int PPC        = 1,
    parameter int CHECK_LOG2 = 3
) (
    input  logic                 out_stream_aclk,
    input  logic                 periph_reset,
    input  logic                 cfg_enable,
    input  logic [1:0]           cfg_mode,
    input  logic [23:0]          cfg_color,
    output logic [32*PPC-1:0]    out_stream_tdata,
    output logic [4*PPC-1:0]     out_stream_tkeep,
    output logic                 out_stream_tlast,
    output logic                 out_stream_tuser,
    output logic                 out_stream_tvalid,
    input  logic                 out_stream_tready,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 busy
);

    localparam int XBEATS = H_RES / PPC;
    localparam int XBW    = (XBEATS > 1) ? $clog2(XBEATS) : 1;
    localparam int YW     = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [XBW-1:0] X_LAST = XBW'(XBEATS - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(V_RES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [XBW-1:0]    x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [1:0]        mode_q, mode_d;
    logic [23:0]       color_q, color_d;
    logic [15:0]       count_d;
    logic              done_d;
    logic              load;
    logic [32*PPC-1:0] data_d;

    function automatic logic [31:0] pixel(input logic [15:0] px, input logic [15:0] py,
                                          input logic [1:0] mode, input logic [23:0] color,
                                          input logic [7:0] fid);
        logic [15:0] chk;
        chk = (px >> CHECK_LOG2) ^ (py >> CHECK_LOG2);
        case (mode)
            2'd0:    pixel = {8'h00, color};
            2'd1:    pixel = {8'h00, px[7:0], px[7:0], px[7:0]};
            2'd2:    pixel = chk[0] ? {8'h00, color} : 32'h0;
            default: pixel = {8'h00, fid, py[7:0], px[7:0]};
        endcase
    endfunction

    // RUN always has tvalid high, so tready alone marks a handshake there.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        color_d = color_q;
        count_d = frame_count;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    state_d = RUN;
                    mode_d  = cfg_mode;
                    color_d = cfg_color;
                    x_d     = '0;
                    y_d     = '0;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (out_stream_tready) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            done_d  = 1'b1;
                            count_d = frame_count + 16'd1;
                            y_d     = '0;
                            if (cfg_enable) begin
                                mode_d  = cfg_mode;
                                color_d = cfg_color;
                                load    = 1'b1;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            y_d  = y_q + 1'b1;
                            load = 1'b1;
                        end
                    end else begin
                        x_d  = x_q + 1'b1;
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        data_d = '0;
        for (int i = 0; i < PPC; i++) begin
            data_d[32*i +: 32] = pixel(16'(x_d) * 16'(PPC) + 16'(i), 16'(y_d),
                                       mode_d, color_d, count_d[7:0]);
        end
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            state_q          <= IDLE;
            x_q              <= '0;
            y_q              <= '0;
            mode_q           <= '0;
            color_q          <= '0;
            frame_count      <= '0;
            frame_done       <= 1'b0;
            out_stream_tdata <= '0;
            out_stream_tlast <= 1'b0;
            out_stream_tuser <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            color_q     <= color_d;
            frame_count <= count_d;
            frame_done  <= done_d;
            if (load) begin
                out_stream_tdata <= data_d;
                out_stream_tlast <= (x_d == X_LAST);
                out_stream_tuser <= (x_d == '0) && (y_d == '0);
            end else if (state_d == IDLE) begin
                out_stream_tlast <= 1'b0;
                out_stream_tuser <= 1'b0;
            end
        end
    end

    assign out_stream_tvalid = (state_q == RUN);
    assign busy              = (state_q == RUN);
    assign out_stream_tkeep  = '1;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// tb/tb_pattern_stream_gen.sv - scoreboard bench for pattern_stream_gen
module tb_pattern_stream_gen;

    logic         clk = 1'b0;
    logic         periph_reset;
    logic         cfg_enable;
    logic [1:0]   cfg_mode;
    logic [23:0]  cfg_color;
    logic [31:0]  tdata;
    logic [3:0]   tkeep;
    logic         tlast, tuser, tvalid, tready;
    logic         frame_done, busy;
    logic [15:0]  frame_count;

    logic         w_enable;
    logic         w_tready;
    logic [127:0] w_tdata;
    logic [15:0]  w_tkeep;
    logic         w_tlast, w_tuser, w_tvalid, w_frame_done, w_busy;
    logic [15:0]  w_frame_count;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] obs[32];
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    pattern_stream_gen #(.H_RES(8), .V_RES(4), .PPC(1), .CHECK_LOG2(1)) u_dut (
        .out_stream_aclk(clk), .periph_reset(periph_reset), .cfg_enable(cfg_enable),
        .cfg_mode(cfg_mode), .cfg_color(cfg_color), .out_stream_tdata(tdata),
        .out_stream_tkeep(tkeep), .out_stream_tlast(tlast), .out_stream_tuser(tuser),
        .out_stream_tvalid(tvalid), .out_stream_tready(tready), .frame_done(frame_done),
        .frame_count(frame_count), .busy(busy)
    );

    pattern_stream_gen #(.H_RES(16), .V_RES(2), .PPC(4), .CHECK_LOG2(3)) u_wide (
        .out_stream_aclk(clk), .periph_reset(periph_reset), .cfg_enable(w_enable),
        .cfg_mode(2'd1), .cfg_color(24'h0), .out_stream_tdata(w_tdata),
        .out_stream_tkeep(w_tkeep), .out_stream_tlast(w_tlast), .out_stream_tuser(w_tuser),
        .out_stream_tvalid(w_tvalid), .out_stream_tready(w_tready), .frame_done(w_frame_done),
        .frame_count(w_frame_count), .busy(w_busy)
    );

    function automatic logic [31:0] model_pix(input int mode, input logic [23:0] color,
                                              input int x, input int y, input int fc);
        logic [7:0] xb, yb, fb;
        xb = 8'(x);
        yb = 8'(y);
        fb = 8'(fc);
        case (mode)
            0: return {8'h00, color};
            1: return {8'h00, xb, xb, xb};
            2: return ((((x >> 1) ^ (y >> 1)) & 1) == 1) ? {8'h00, color} : 32'h0;
            default: return {8'h00, fb, yb, xb};
        endcase
    endfunction

    task automatic push_frame(input int mode, input logic [23:0] color, input int fc);
        beat_t b;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                b.data = model_pix(mode, color, x, y, fc);
                b.last = (x == 7);
                b.user = (x == 0) && (y == 0);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic drain_frame(input int ready_pct, input int drop_at);
        int          beats = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [31:0] pd;
        logic        pl, pu;
        beat_t       e;
        while (beats < 32 && cyc < 3000) begin
            if (stalled) begin
                tests_run++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl || tuser !== pu) begin
                    tests_failed++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b user=%b, required valid=1 data=%h last=%b user=%b",
                             tvalid, tdata, tlast, tuser, pd, pl, pu);
                end
            end
            tready  = ($urandom_range(0, 99) < ready_pct);
            stalled = tvalid && !tready;
            pd = tdata;
            pl = tlast;
            pu = tuser;
            if (tvalid && tready) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL scoreboard_empty: beat %0d data=%h with no expected beat", beats, tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (tdata !== e.data || tlast !== e.last || tuser !== e.user) begin
                        tests_failed++;
                        $display("FAIL beat_%0d: data=%h last=%b user=%b, required data=%h last=%b user=%b",
                                 beats, tdata, tlast, tuser, e.data, e.last, e.user);
                    end
                end
                obs[beats] = tdata;
                beats++;
                if (beats == drop_at) cfg_enable = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        tests_run++;
        if (beats != 32) begin
            tests_failed++;
            $display("FAIL beat_count: got %0d beats in %0d cycles, required 32", beats, cyc);
        end
    endtask

    task automatic do_reset();
        periph_reset = 1'b1;
        cfg_enable   = 1'b0;
        w_enable     = 1'b0;
        tready       = 1'b0;
        repeat (2) @(negedge clk);
        periph_reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0 || frame_done !== 1'b0 ||
            busy !== 1'b0 || tdata !== 32'h0 || frame_count !== 16'h0 || tkeep !== 4'hF) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b last=%b user=%b done=%b busy=%b data=%h count=%h keep=%h, required 0/0/0/0/0/0/0/f",
                     tvalid, tlast, tuser, frame_done, busy, tdata, frame_count, tkeep);
        end
    endtask

    task automatic test_solid();
        do_reset();
        cfg_mode   = 2'd0;
        cfg_color  = 24'h123456;
        cfg_enable = 1'b1;
        push_frame(0, 24'h123456, 0);
        @(negedge clk);
        tests_run++;
        if (tvalid !== 1'b1 || tuser !== 1'b1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sof_latency: valid=%b user=%b busy=%b, required 1/1/1", tvalid, tuser, busy);
        end
        drain_frame(100, 0);
        tests_run++;
        if (frame_done !== 1'b1 || frame_count !== 16'd1 || tvalid !== 1'b1 || tuser !== 1'b1) begin
            tests_failed++;
            $display("FAIL solid_frame_end: done=%b count=%0d valid=%b user=%b, required 1/1/1/1",
                     frame_done, frame_count, tvalid, tuser);
        end
        tready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (frame_done !== 1'b0 || tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_pulse_width: done=%b valid=%b, required 0/1", frame_done, tvalid);
        end
    endtask

    task automatic test_wide_hgrad();
        logic [127:0] wexp;
        int           x;
        do_reset();
        w_tready = 1'b1;
        w_enable = 1'b1;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 4; i++) begin
                x = (b % 4) * 4 + i;
                wexp[32*i +: 32] = {8'h00, 8'(x), 8'(x), 8'(x)};
            end
            tests_run++;
            if (w_tvalid !== 1'b1 || w_tdata !== wexp || w_tlast !== (b % 4 == 3) || w_tuser !== (b == 0)) begin
                tests_failed++;
                $display("FAIL wide_beat_%0d: valid=%b data=%h last=%b user=%b, required data=%h",
                         b, w_tvalid, w_tdata, w_tlast, w_tuser, wexp);
            end
            if (b == 1) begin
                tests_run++;
                if (w_tdata !== {32'h00070707, 32'h00060606, 32'h00050505, 32'h00040404}) begin
                    tests_failed++;
                    $display("FAIL wide_beat1_literal: data=%h, required 00070707000606060005050500040404", w_tdata);
                end
            end
            if (b == 7) w_enable = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (w_frame_done !== 1'b1 || w_frame_count !== 16'd1 || w_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wide_frame_end: done=%b count=%0d valid=%b, required 1/1/0",
                     w_frame_done, w_frame_count, w_tvalid);
        end
    endtask

    task automatic test_checker_backpressure();
        do_reset();
        cfg_mode   = 2'd2;
        cfg_color  = 24'hFFFFFF;
        cfg_enable = 1'b1;
        push_frame(2, 24'hFFFFFF, 0);
        @(negedge clk);
        drain_frame(50, 0);
        tests_run++;
        if (obs[2] !== 32'h00FFFFFF || obs[18] !== 32'h0) begin
            tests_failed++;
            $display("FAIL checker_pixels: (2,0)=%h (2,2)=%h, required 00ffffff/00000000", obs[2], obs[18]);
        end
        tests_run++;
        if (frame_done !== 1'b1 || tuser !== 1'b1 || frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL checker_frame_end: done=%b user=%b count=%0d, required 1/1/1", frame_done, tuser, frame_count);
        end
        cfg_enable = 1'b0;
        tready     = 1'b0;
    endtask

    task automatic test_enable_drop();
        do_reset();
        cfg_mode   = 2'd0;
        cfg_color  = 24'hABCDEF;
        cfg_enable = 1'b1;
        push_frame(0, 24'hABCDEF, 0);
        @(negedge clk);
        drain_frame(100, 10);
        tests_run++;
        if (frame_done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_drop_end: done=%b valid=%b busy=%b, required 1/0/0", frame_done, tvalid, busy);
        end
        @(negedge clk);
        tests_run++;
        if (tvalid !== 1'b0 || frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL enable_drop_idle: valid=%b count=%0d, required 0/1", tvalid, frame_count);
        end
    endtask

    task automatic test_mode_change();
        do_reset();
        cfg_mode   = 2'd0;
        cfg_color  = 24'h010203;
        cfg_enable = 1'b1;
        push_frame(0, 24'h010203, 0);
        push_frame(3, 24'h777777, 1);
        @(negedge clk);
        cfg_mode  = 2'd3;
        cfg_color = 24'h777777;
        drain_frame(100, 0);
        drain_frame(100, 0);
        tests_run++;
        if (obs[0][23:16] !== 8'h01 || frame_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL mode_change_next: R=%h count=%0d, required 01/2", obs[0][23:16], frame_count);
        end
        cfg_enable = 1'b0;
        tready     = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        cfg_mode   = 2'd0;
        cfg_color  = 24'h445566;
        cfg_enable = 1'b1;
        push_frame(0, 24'h445566, 0);
        @(negedge clk);
        drain_frame(100, 0);
        tests_run++;
        if (frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL pre_reset_count: count=%0d, required 1", frame_count);
        end
        tready = 1'b1;
        repeat (5) @(negedge clk);
        tready       = 1'b0;
        periph_reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (tvalid !== 1'b0 || frame_count !== 16'd0 || busy !== 1'b0 || tuser !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: valid=%b count=%0d busy=%b user=%b, required 0/0/0/0",
                     tvalid, frame_count, busy, tuser);
        end
        periph_reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== 32'h00445566) begin
            tests_failed++;
            $display("FAIL restart_sof: valid=%b user=%b data=%h, required 1/1/00445566", tvalid, tuser, tdata);
        end
        cfg_enable = 1'b0;
    endtask

    initial begin
        periph_reset = 1'b1;
        cfg_enable   = 1'b0;
        cfg_mode     = 2'd0;
        cfg_color    = 24'h0;
        tready       = 1'b0;
        w_enable     = 1'b0;
        w_tready     = 1'b1;
        @(negedge clk);
        test_reset();
        test_solid();
        test_wide_hgrad();
        test_checker_backpressure();
        test_enable_drop();
        test_mode_change();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_stream_gen.md
# pattern_stream_gen

Parametrised AXI4-Stream video test-pattern source, the successor to the single-pattern pixel generator that feeds the video DMA/VDMA path. It emits complete frames of `H_RES` x `V_RES` pixels, with `PPC` pixels per beat, and marks frames and lines with `tuser` (start of frame) and `tlast` (end of line). It offers four selectable patterns, takes configuration only at frame boundaries, respects full backpressure, and counts frames. It sits in the stream domain and replaces the Mandelbrot core during display-path bring-up.

## Interface
Parameters:
- `H_RES`, 640, active pixels per line; must be a multiple of `PPC`.
- `V_RES`, 480, lines per frame.
- `PPC`, 1, pixels per beat; legal values 1, 2, 4.
- `CHECK_LOG2`, 3, log2 of checker square size in pixels.

Ports:
- `out_stream_aclk`  in  1  the single clock; all logic is on the rising edge.
- `periph_reset`  in  1  reset; synchronous, active-high.
- `cfg_enable`  in  1  run frames while high; sampled at frame boundaries.
- `cfg_mode`  in  2  pattern select: 0 SOLID, 1 HGRAD, 2 CHECKER, 3 FRAME_ID.
- `cfg_color`  in  24  {R,G,B} used by SOLID and CHECKER.
- `out_stream_tdata`  out  32*PPC  pixel i occupies bits [32i+31:32i] as {8'h00,R,G,B}.
- `out_stream_tkeep`  out  4*PPC  all ones.
- `out_stream_tlast`  out  1  set on the last beat of each line.
- `out_stream_tuser`  out  1  set on the first beat of each frame only.
- `out_stream_tvalid`  out  1  beat valid.
- `out_stream_tready`  in  1  sink ready.
- `frame_done`  out  1  one-cycle pulse after the last beat of a frame is accepted.
- `frame_count`  out  16  frames completed; wraps 0xFFFF -> 0.
- `busy`  out  1  high in RUN.

## Operation
- State machine with two states:
  - IDLE: `tvalid`=0, `busy`=0.
  - RUN: beats are presented.
- IDLE -> RUN when `cfg_enable`=1 is sampled. On that edge the block latches `cfg_mode` and `cfg_color` into `mode_q` and `color_q`, sets x_beat=0 and y=0, and presents the first beat with `tuser`=1.
- A beat advances only on `tvalid && tready`:
  - x_beat increments.
  - At x_beat = `H_RES`/`PPC`-1, x_beat wraps to 0 and y increments.
  - At y = `V_RES`-1 the frame ends.
- Frame end, on the handshake of the final beat:
  - `frame_done` pulses and `frame_count` increments.
  - If `cfg_enable`=1 on that edge: re-latch config and present the next frame's SOF beat immediately. Stay in RUN with no bubble.
  - Otherwise go to IDLE.
- Deasserting `cfg_enable` mid-frame has no effect until the frame completes. Frames are never truncated.
- Config inputs changing mid-frame have no effect on the current frame.
- Pixel x = x_beat*`PPC`+i. Pattern per pixel:
  - SOLID: `color_q`.
  - HGRAD: R=G=B=x[7:0]; wraps every 256 pixels.
  - CHECKER: `color_q` if (x>>`CHECK_LOG2`)^(y>>`CHECK_LOG2`) has LSB 1, else 0.
  - FRAME_ID: R=`frame_count`[7:0], G=y[7:0], B=x[7:0].
- `tuser`=1 iff x_beat=0 and y=0. `tlast`=1 iff x_beat=`H_RES`/`PPC`-1.
- All stream outputs are registered; no combinational path from `tready` to any output.

## Timing
- Reset values:
  - `tvalid`, `tlast`, `tuser`, `frame_done`, `busy` = 0.
  - `tdata` = 0, `frame_count` = 0.
  - `tkeep` = all ones.
  - State IDLE; x, y, `mode_q`, `color_q` = 0.
- Reset in any state, including mid-frame with `tvalid`=1: outputs take reset values on the next edge. There is no partial-frame resume.
- Latency: `cfg_enable` high at edge k (in IDLE) gives `tvalid`=1 with the SOF beat during cycle k+1.
- Backpressure: while `tvalid`=1 and `tready`=0, `tdata`/`tlast`/`tuser`/`tvalid` hold stable. `tvalid` never drops without a handshake.
- Throughput: one beat per cycle with `tready` held at 1.
- A frame takes `H_RES`*`V_RES`/`PPC` handshakes.
- `frame_done` is asserted in the cycle after the final handshake.
  - `frame_count` shows the new value in that same cycle.
  - The next frame's SOF beat, if any, is also valid in that same cycle.

## Test plan
- Reset, `cfg_enable`=1, mode 0, `cfg_color`=24'h123456, `tready`=1, H_RES=8, V_RES=4, PPC=1:
  - 32 beats, all `tdata`=32'h00123456.
  - `tuser` on beat 0 only; `tlast` on beats 7, 15, 23, 31.
  - `frame_done` pulses once; `frame_count`=1; the next SOF follows with no gap.
- PPC=4, H_RES=16, mode 1, `tready`=1:
  - Beat 1 `tdata` = {32'h00070707, 32'h00060606, 32'h00050505, 32'h00040404}.
  - `tlast` on every 4th beat.
- Random `tready` (50%), mode 2, CHECK_LOG2=1, `cfg_color`=24'hFFFFFF:
  - Outputs stable across every stall.
  - Pixel (2,0) = 32'h00FFFFFF and pixel (2,2) = 0.
  - The 32-beat total is still exact.
- Drop `cfg_enable` at beat 10 of a frame: the frame finishes all 32 beats, then `tvalid`=0 and `busy`=0.
- Change `cfg_mode` 0->3 mid-frame: the current frame stays SOLID; the next frame is FRAME_ID with R=8'h01.
- Assert `periph_reset` for one cycle at beat 5 while `tready`=0: the next cycle shows `tvalid`=0 and `frame_count`=0. After release, the next frame starts with SOF.
